// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution layer: default word
// format, FSM state encoding and the saturating fixed-point rescale.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPUTE = 3'd1,
    ST_FINAL   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Arithmetic right shift by frac (floor rounding) followed by clamping
  // to the signed range of a width-bit word. Works on a 64-bit carrier so
  // any accumulator up to 63 bits can be passed in after sign extension.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int frac,
                                                   input int width);
    logic signed [63:0] shifted;
    logic signed [63:0] maxVal;
    logic signed [63:0] minVal;
    shifted = value >>> frac;
    maxVal  = (64'sd1 <<< (width - 1)) - 64'sd1;
    minVal  = -(64'sd1 <<< (width - 1));
    if (shifted > maxVal) begin
      return maxVal;
    end else if (shifted < minVal) begin
      return minVal;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output-pixel lane: signed multiply-accumulate over the filter taps,
// then bias add, rescale and saturation into a registered result word.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC       = DEF_FRAC,
  parameter int ACC_W      = 2 * DEF_DATA_WIDTH + 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_enable,
  input  logic                         i_finalize,
  input  logic                         i_active,
  input  logic signed [DATA_WIDTH-1:0] i_pixel,
  input  logic signed [DATA_WIDTH-1:0] i_tap,
  input  logic signed [DATA_WIDTH-1:0] i_bias,
  output logic signed [DATA_WIDTH-1:0] o_result
);

  logic signed [ACC_W-1:0]        r_acc;
  logic signed [2*DATA_WIDTH-1:0] w_product;
  logic signed [ACC_W-1:0]        w_productExt;
  logic signed [63:0]             w_accExt;
  logic signed [63:0]             w_biasExt;
  logic signed [63:0]             w_biased;
  logic signed [DATA_WIDTH-1:0]   w_finalWord;

  // Full-precision product and the biased, rescaled, saturated pixel value
  always_comb begin
    w_product    = i_pixel * i_tap;
    w_productExt = {{(ACC_W - 2*DATA_WIDTH){w_product[2*DATA_WIDTH-1]}}, w_product};
    w_accExt     = {{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_biasExt    = {{(64 - DATA_WIDTH){i_bias[DATA_WIDTH-1]}}, i_bias};
    w_biased     = w_accExt + (w_biasExt <<< FRAC);
    w_finalWord  = DATA_WIDTH'(sat_shift(w_biased, FRAC, DATA_WIDTH));
  end

  // Accumulator: cleared at the start of every chunk, one tap per enabled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc + w_productExt;
    end
  end

  // Result register: lanes past the right edge of the row report zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_result <= '0;
    end else if (i_finalize) begin
      o_result <= i_active ? w_finalWord : '0;
    end
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Strided multi-channel 2-D convolution producing each output row as
// chunks of P pixels on a valid/ready stream. The frame and filter are
// captured on start; P lanes walk the C_IN*F*F taps in lockstep.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC       = DEF_FRAC,
  parameter int C_IN       = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int S          = 1,
  parameter int P          = 4,
  localparam int OH        = (H - F) / S + 1,
  localparam int OW        = (W - F) / S + 1,
  localparam int K         = C_IN * F * F,
  localparam int ROW_W     = (OH > 1) ? $clog2(OH) : 1,
  localparam int COL_W     = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [C_IN*H*W*DATA_WIDTH-1:0] image,
  input  logic [K*DATA_WIDTH-1:0]        filter,
  input  logic [DATA_WIDTH-1:0]          bias,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [P*DATA_WIDTH-1:0]        out_data,
  output logic [P-1:0]                   out_mask,
  output logic [ROW_W-1:0]               out_row,
  output logic [COL_W-1:0]               out_col,
  output logic                           out_last,
  output logic                           done
);

  localparam int ACC_W = 2 * DATA_WIDTH + ((K > 1) ? $clog2(K) : 1);
  localparam int FC_W  = (F > 1) ? $clog2(F) : 1;
  localparam int CH_W  = (C_IN > 1) ? $clog2(C_IN) : 1;

  state_t                         r_state;
  logic [C_IN*H*W*DATA_WIDTH-1:0] r_image;
  logic [K*DATA_WIDTH-1:0]        r_filter;
  logic signed [DATA_WIDTH-1:0]   r_bias;
  logic [ROW_W-1:0]               r_row;
  logic [COL_W-1:0]               r_col;
  logic [FC_W-1:0]                r_fx;
  logic [FC_W-1:0]                r_fy;
  logic [CH_W-1:0]                r_ch;
  logic                           r_busy;
  logic                           r_valid;
  logic                           r_last;
  logic                           r_done;
  logic [P-1:0]                   r_outMask;
  logic [ROW_W-1:0]               r_outRow;
  logic [COL_W-1:0]               r_outCol;

  logic                           w_clear;
  logic                           w_enable;
  logic                           w_finalize;
  logic                           w_lastTap;
  logic                           w_rowEnd;
  logic                           w_frameEnd;
  logic                           w_handshake;
  logic [P-1:0]                   w_laneActive;
  logic signed [DATA_WIDTH-1:0]   w_pixel  [P];
  logic signed [DATA_WIDTH-1:0]   w_result [P];
  logic signed [DATA_WIDTH-1:0]   w_tap;

  // Lane and sequencing strobes derived from the current state
  always_comb begin
    w_handshake = (r_state == ST_HOLD) && out_ready;
    w_clear     = ((r_state == ST_IDLE) && start) || w_handshake;
    w_enable    = (r_state == ST_COMPUTE);
    w_finalize  = (r_state == ST_FINAL);
    w_lastTap   = (r_ch == CH_W'(C_IN - 1)) && (r_fy == FC_W'(F - 1)) && (r_fx == FC_W'(F - 1));
    w_rowEnd    = (int'(r_col) + P) >= OW;
    w_frameEnd  = w_rowEnd && (int'(r_row) == OH - 1);
  end

  // Operand fetch: the shared filter tap and one image word per active lane
  always_comb begin
    int tapIdx;
    int pixIdx;
    tapIdx       = 0;
    pixIdx       = 0;
    w_laneActive = '0;
    for (int n = 0; n < P; n++) begin
      w_pixel[n] = '0;
    end
    tapIdx = (int'(r_ch) * F + int'(r_fy)) * F + int'(r_fx);
    w_tap  = r_filter[tapIdx*DATA_WIDTH +: DATA_WIDTH];
    for (int n = 0; n < P; n++) begin
      w_laneActive[n] = (int'(r_col) + n) < OW;
      if (w_laneActive[n]) begin
        pixIdx = int'(r_ch) * H * W
               + (int'(r_row) * S + int'(r_fy)) * W
               + (int'(r_col) + n) * S + int'(r_fx);
        w_pixel[n] = r_image[pixIdx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Frame operands are captured once per accepted start and held to the end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_image  <= '0;
      r_filter <= '0;
      r_bias   <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_image  <= image;
      r_filter <= filter;
      r_bias   <= bias;
    end
  end

  // Main sequencer: tap walk, chunk finalisation, output hold and row/column stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_fx      <= '0;
      r_fy      <= '0;
      r_ch      <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_outMask <= '0;
      r_outRow  <= '0;
      r_outCol  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= start;
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_ch    <= '0;
            r_state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (w_lastTap) begin
            r_fx    <= '0;
            r_fy    <= '0;
            r_ch    <= '0;
            r_state <= ST_FINAL;
          end else if (r_fx == FC_W'(F - 1)) begin
            r_fx <= '0;
            if (r_fy == FC_W'(F - 1)) begin
              r_fy <= '0;
              r_ch <= r_ch + CH_W'(1);
            end else begin
              r_fy <= r_fy + FC_W'(1);
            end
          end else begin
            r_fx <= r_fx + FC_W'(1);
          end
        end
        ST_FINAL: begin
          r_valid   <= 1'b1;
          r_last    <= w_frameEnd;
          r_outMask <= w_laneActive;
          r_outRow  <= r_row;
          r_outCol  <= r_col;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_state <= ST_DONE;
            end else begin
              if (w_rowEnd) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
              end else begin
                r_col <= r_col + COL_W'(P);
              end
              r_state <= ST_COMPUTE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar n = 0; n < P; n++) begin : g_lane
    conv_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC       (FRAC),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_enable   (w_enable),
      .i_finalize (w_finalize),
      .i_active   (w_laneActive[n]),
      .i_pixel    (w_pixel[n]),
      .i_tap      (w_tap),
      .i_bias     (r_bias),
      .o_result   (w_result[n])
    );
    assign out_data[n*DATA_WIDTH +: DATA_WIDTH] = w_result[n];
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_mask  = r_outMask;
  assign out_row   = r_outRow;
  assign out_col   = r_outCol;
  assign done      = r_done;

endmodule
